// File: rtl/median6_window_feeder.sv
// median6_window_feeder: keeps the last six accepted samples and presents them as a window (num1 oldest .. num6 newest) under valid/ready; ports clk, rst, in_valid/in_ready/in_data, out_valid/out_ready, num1..num6, fill_level; optional flush port when MEDIAN6_WINDOW_FLUSH_EN is defined
module median6_window_feeder #(
  parameter int DATA_W = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEDIAN6_WINDOW_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] num3,
  output logic [DATA_W-1:0] num4,
  output logic [DATA_W-1:0] num5,
  output logic [DATA_W-1:0] num6,
  output logic [2:0]        fill_level
);
  logic [DATA_W-1:0] win_q [6];
  logic [DATA_W-1:0] win_d [6];
  logic [2:0] fill_q, fill_d, cnt_q, cnt_d;
  logic valid_q, valid_d, flush_i, acc, done;
`ifdef MEDIAN6_WINDOW_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif
  always_comb begin
    in_ready = !(valid_q && !out_ready) && !flush_i;
    acc = in_valid && in_ready;
    done = acc && (fill_q == 3'd5 || (fill_q == 3'd6 && cnt_q + 3'd1 == 3'(STRIDE)));
    for (int i = 0; i < 5; i++) win_d[i] = flush_i ? '0 : acc ? win_q[i+1] : win_q[i];
    win_d[5] = flush_i ? '0 : acc ? in_data : win_q[5];
    fill_d = flush_i ? 3'd0 : (acc && fill_q != 3'd6) ? fill_q + 3'd1 : fill_q;
    cnt_d = (flush_i || done) ? 3'd0 : acc ? cnt_q + 3'd1 : cnt_q;
    valid_d = !flush_i && (done || (valid_q && !out_ready));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '{default: '0};
      fill_q  <= 3'd0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign num1 = win_q[0];
  assign num2 = win_q[1];
  assign num3 = win_q[2];
  assign num4 = win_q[3];
  assign num5 = win_q[4];
  assign num6 = win_q[5];
  assign out_valid = valid_q;
  assign fill_level = fill_q;
endmodule

// File: tb/tb_median6_window_feeder.sv
// tb_median6_window_feeder: directed checks of median6_window_feeder at STRIDE 1, 3 and 6 (flush checks when MEDIAN6_WINDOW_FLUSH_EN is defined)
module tb_median6_window_feeder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, flush = 0;
  logic [3:0] in_data = '0;
  logic [23:0] win [3];
  logic ov [3], ir [3];
  logic [2:0] fl [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [3:0] a, b, c, d, e, f;
    logic v, r;
    logic [2:0] l;
    median6_window_feeder #(.DATA_W(4), .STRIDE(g == 0 ? 1 : g == 1 ? 3 : 6)) dut (
      .clk(clk), .rst(rst),
`ifdef MEDIAN6_WINDOW_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(r), .in_data(in_data),
      .out_valid(v), .out_ready(out_ready),
      .num1(a), .num2(b), .num3(c), .num4(d), .num5(e), .num6(f),
      .fill_level(l));
    assign win[g] = {a, b, c, d, e, f};
    assign ov[g] = v;
    assign ir[g] = r;
    assign fl[g] = l;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input int v);
    in_valid = 1;
    in_data = 4'(v);
    step();
  endtask
  task automatic do_reset;
    in_valid = 0;
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    int nxt, got;
    logic seen, acc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ov", 32'(ov[k]), 0);
      chk("rst_fill", 32'(fl[k]), 0);
      chk("rst_win", 32'(win[k]), 0);
      chk("rst_ready", 32'(ir[k]), 1);
    end
    out_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      feed(i);
      chk("fill_ov", 32'(ov[0]), 32'(i == 6));
      chk("fill_level", 32'(fl[0]), 32'(i));
    end
    chk("fill_win", 32'(win[0]), 32'h123456);
    feed(7);
    chk("slide_win", 32'(win[0]), 32'h234567);
    chk("slide_ov", 32'(ov[0]), 1);
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 6; i++) feed(i);
    chk("bp_ov", 32'(ov[0]), 1);
    in_data = 4'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(ir[0]), 0);
      step();
      chk("bp_win", 32'(win[0]), 32'h123456);
      chk("bp_fill", 32'(fl[0]), 6);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(ir[0]), 1);
    step();
    chk("bp_next_win", 32'(win[0]), 32'h234569);
    chk("bp_next_ov", 32'(ov[0]), 1);
    in_valid = 0;
    step();
    chk("bp_drain_ov", 32'(ov[0]), 0);
    do_reset();
    out_ready = 1;
    for (int i = 1; i <= 12; i++) begin
      feed(i);
      chk("s3_ov", 32'(ov[1]), 32'(i == 6 || i == 9 || i == 12));
      if (i == 6) chk("s3_win1", 32'(win[1]), 32'h123456);
      if (i == 9) chk("s3_win2", 32'(win[1]), 32'h456789);
      if (i == 12) chk("s3_win3", 32'(win[1]), 32'h789abc);
    end
    do_reset();
    for (int i = 1; i <= 4; i++) feed(i);
    in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("midrst_fill", 32'(fl[0]), 0);
    chk("midrst_ov", 32'(ov[0]), 0);
    chk("midrst_win", 32'(win[0]), 0);
    for (int i = 0; i < 6; i++) begin
      feed(10 + i);
      chk("midrst_refill_ov", 32'(ov[0]), 32'(i == 5));
    end
    chk("midrst_win2", 32'(win[0]), 32'habcdef);
    do_reset();
    nxt = 1;
    got = 0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      out_ready = c[0];
      in_valid = nxt <= 12;
      in_data = 4'(nxt);
      #1;
      if (ov[2] && out_ready) begin
        if (got < 2) chk("s6_win", 32'(win[2]), got == 0 ? 32'h123456 : 32'h789abc);
        got++;
      end
      if (ov[2]) seen = 1;
      if (seen) chk("s6_fill", 32'(fl[2]), 6);
      acc = in_valid && ir[2];
      step();
      if (acc) nxt++;
    end
    chk("s6_windows", 32'(got), 2);
    chk("s6_accepts", 32'(nxt), 13);
`ifdef MEDIAN6_WINDOW_FLUSH_EN
    do_reset();
    out_ready = 1;
    for (int i = 1; i <= 6; i++) feed(i);
    chk("fl_pre_ov", 32'(ov[0]), 1);
    flush = 1;
    in_valid = 1;
    in_data = 4'd7;
    #1;
    chk("fl_ready", 32'(ir[0]), 0);
    step();
    flush = 0;
    in_valid = 0;
    chk("fl_ov", 32'(ov[0]), 0);
    chk("fl_fill", 32'(fl[0]), 0);
    chk("fl_win", 32'(win[0]), 0);
    for (int i = 1; i <= 6; i++) begin
      feed(i);
      chk("fl_refill_ov", 32'(ov[0]), 32'(i == 6));
    end
    in_valid = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
